// File: rtl/mac_pkg.sv
// Shared definitions for the MAC front end and related blocks.
//   feed_state_t : feeder FSM states
//   idx_width()  : index counter width for an n-entry vector, max(1, clog2(n))
package mac_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoadW,
        StLoadI,
        StFire
    } feed_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_vec_shreg.sv
// Indexed-write vector register: Depth entries of Width bits, one entry written per
// enabled cycle at idx_i. The whole vector is visible in parallel on vec_o.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears every entry
//   we_i    : write enable
//   idx_i   : entry index to write
//   wdata_i : write data
//   vec_o   : all entries, entry 0 in the low bits
module mac_vec_shreg
    import mac_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 49,
    localparam int unsigned IdxW = idx_width(Depth)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we_i,
    input  logic [IdxW-1:0]             idx_i,
    input  logic [Width-1:0]            wdata_i,
    output logic [Depth-1:0][Width-1:0] vec_o
);

    logic [Depth-1:0][Width-1:0] vec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
        end else if (we_i) begin
            vec_q[idx_i] <= wdata_i;
        end
    end

    assign vec_o = vec_q;

endmodule

// File: rtl/mac_vec_feeder.sv
// Word-serial to vector-parallel feeder for the MAC engines. Words arrive over a
// valid/ready stream (element 0 first), are packed into a weight vector and an image
// vector, then a one-cycle o_val/o_done pulse is issued with both vectors held stable.
// Weights may be kept and reused across image windows.
//   clk, rst            : clock and synchronous active-high reset
//   i_start, i_load_w   : command pulse (IDLE only); i_load_w=1 loads weights first
//   s_val, s_data, s_rdy: input word stream
//   o_Weight, o_Img     : packed vectors, element 0 in the low bits
//   o_val, o_done       : one-cycle vector-valid pulse
//   o_busy              : not in IDLE
//   o_w_loaded          : stored weight vector is complete
//   o_err               : one-cycle pulse, reuse requested without stored weights
module mac_vec_feeder
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_INPUT = 49
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic                          i_load_w,
    input  logic                          s_val,
    input  logic [WIDTH-1:0]              s_data,
    output logic                          s_rdy,
    output logic [N_INPUT-1:0][WIDTH-1:0] o_Weight,
    output logic [N_INPUT-1:0][WIDTH-1:0] o_Img,
    output logic                          o_val,
    output logic                          o_done,
    output logic                          o_busy,
    output logic                          o_w_loaded,
    output logic                          o_err
);

    localparam int unsigned IdxW = idx_width(N_INPUT);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(N_INPUT - 1);

    feed_state_t     state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            w_loaded_q, w_loaded_d;
    logic            err_q, err_d;
    logic            hs, last, we_w, we_img;

    assign s_rdy = (state_q == StLoadW) || (state_q == StLoadI);
    assign hs    = s_val & s_rdy;
    assign last  = (idx_q == IdxLast);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        w_loaded_d = w_loaded_q;
        err_d      = 1'b0;
        we_w       = 1'b0;
        we_img     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (!i_load_w && w_loaded_q) begin
                        state_d = StLoadI;
                    end else begin
                        // Explicit load, or reuse with nothing stored: load weights.
                        state_d    = StLoadW;
                        w_loaded_d = 1'b0;
                        err_d      = !i_load_w;
                    end
                end
            end
            StLoadW: begin
                if (hs) begin
                    we_w = 1'b1;
                    if (last) begin
                        idx_d      = '0;
                        w_loaded_d = 1'b1;
                        state_d    = StLoadI;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StLoadI: begin
                if (hs) begin
                    we_img = 1'b1;
                    if (last) begin
                        idx_d   = '0;
                        state_d = StFire;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StFire: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            w_loaded_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            w_loaded_q <= w_loaded_d;
            err_q      <= err_d;
        end
    end

    assign o_val      = (state_q == StFire);
    assign o_done     = (state_q == StFire);
    assign o_busy     = (state_q != StIdle);
    assign o_w_loaded = w_loaded_q;
    assign o_err      = err_q;

    mac_vec_shreg #(
        .Width (WIDTH),
        .Depth (N_INPUT)
    ) u_weight (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_w),
        .idx_i   (idx_q),
        .wdata_i (s_data),
        .vec_o   (o_Weight)
    );

    mac_vec_shreg #(
        .Width (WIDTH),
        .Depth (N_INPUT)
    ) u_image (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_img),
        .idx_i   (idx_q),
        .wdata_i (s_data),
        .vec_o   (o_Img)
    );

endmodule

// File: doc/mac_vec_feeder.md
Name: mac_vec_feeder

Overview:
- Word-serial to vector-parallel front end for the MAC engines (pipelined or iterative variant).
- Accepts weights and image pixels one word per cycle over a valid/ready stream.
- Packs them into N_INPUT-wide weight and image vectors, then fires a single-cycle valid pulse with vectors held stable.
- Supports weight-stationary operation: weights are loaded once and reused across many image windows.

Parameters:
WIDTH, 32, bit width of every weight/pixel word (signed two's complement)
N_INPUT, 49, elements per vector (7x7 window); legal range 1..1024

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_start  in  1  command pulse: begin one vector load; sampled only in IDLE
i_load_w  in  1  qualifies i_start: 1 = load new weights before image, 0 = reuse stored weights
s_val  in  1  input word valid
s_data  in  WIDTH  input word (signed)
s_rdy  out  1  feeder accepts s_data this cycle when s_val&s_rdy
o_Weight  out  WIDTH x [N_INPUT-1:0]  weight vector to MAC
o_Img  out  WIDTH x [N_INPUT-1:0]  image vector to MAC
o_val  out  1  one-cycle vector-valid pulse to MAC i_val
o_done  out  1  one-cycle pulse, coincident with o_val
o_busy  out  1  high in any state other than IDLE
o_w_loaded  out  1  stored weight vector is valid
o_err  out  1  one-cycle pulse: reuse requested with no weights loaded

Behaviour:
- Reset values: o_val=0, o_done=0, o_busy=0, o_w_loaded=0, o_err=0, s_rdy=0, every o_Weight/o_Img element=0, index counter=0, state=IDLE.
- Reset mid-operation aborts the load; all partial data is discarded and all outputs return to reset values the next cycle.
- FSM states: IDLE, LOAD_W, LOAD_I, FIRE.
- IDLE: s_rdy=0.
  - i_start&i_load_w -> LOAD_W.
  - i_start&!i_load_w&o_w_loaded -> LOAD_I.
  - i_start&!i_load_w&!o_w_loaded -> o_err pulses next cycle and state -> LOAD_W (forced weight load).
  - i_start outside IDLE is ignored, with no error.
- LOAD_W: s_rdy=1.
  - Each handshake writes o_Weight[idx] <= s_data and increments idx.
  - The handshake at idx=N_INPUT-1 clears idx, sets o_w_loaded, and moves to LOAD_I.
  - o_w_loaded is cleared on entry to LOAD_W, so an interrupted load never leaves stale weights marked valid.
- LOAD_I: s_rdy=1.
  - Each handshake writes o_Img[idx] and increments idx.
  - The handshake at idx=N_INPUT-1 clears idx and moves to FIRE.
- FIRE: s_rdy=0, o_val=1, o_done=1 for exactly this one cycle; next state IDLE.
- Stall handling: s_val low in a LOAD state holds idx and state, with no timeout.
- Stream order: element 0 first.
- Latency: last image handshake at edge e -> o_val high in the cycle following edge e.
  - Minimum start-to-start period is 2N+2 cycles with load, N+2 with reuse.
- Output holding: o_Weight/o_Img are registers and change only on their own handshakes.
  - During FIRE and IDLE both vectors are stable.
  - o_Weight persists across reuse commands.
- No arithmetic: data pass through bit-exact; index counter width is max(1,$clog2(N_INPUT)).
- N_INPUT=1: each LOAD state lasts exactly one handshake; idx stays 0.
- The MAC has no backpressure, so the feeder never waits for MAC results. Result collection belongs to the consumer of o_sum/o_val.

Decomposition:
- Shared package mac_pkg: FSM state enum (feed_state_t: IDLE, LOAD_W, LOAD_I, FIRE) and a localparam function for index width, max(1,$clog2(n)). The MAC and future blocks share these.
- One natural sub-module: mac_vec_shreg, an indexed write register file of N_INPUT x WIDTH with write enable and index. It is instantiated twice (weights, image).
- FSM and handshake logic stay in the top.

Test Plan:
- Reset then load, N_INPUT=4: i_start, i_load_w=1, stream 1,2,3,4,5,6,7,8 with s_val continuous -> o_Weight={1,2,3,4}, o_Img={5,6,7,8}, o_val/o_done single pulse 1 cycle after word 8, o_w_loaded=1. A downstream MAC returns sum 70.
- Weight reuse: after the previous load, i_start, i_load_w=0, stream -1,-2,-3,-4 -> o_Weight unchanged {1,2,3,4}, o_Img={-1,-2,-3,-4}, o_val 5 cycles after start (N+1), MAC sum -30.
- Reuse with no weights after reset: i_start, i_load_w=0 -> o_err pulse one cycle, FSM in LOAD_W, first 4 words land in o_Weight.
- Stream stalls: s_val toggled 1,0,0,1,... through a full load -> idx holds during gaps, s_rdy stays 1, final vectors correct, exactly one o_val.
- Reset mid-load after 3 weight words -> all outputs zero next cycle, o_w_loaded=0. The following full load produces correct vectors.
- i_start pulsed while in LOAD_I and FIRE -> ignored, exactly one o_val per accepted command. With N_INPUT=1, words 9,3 -> o_Weight[0]=9, o_Img[0]=3.
